res_streamer: RTL

Result read-out engine for the accelerator. After the control block signals completion, it serialises the flattened 32x32 post-ReLU result bus (the `res` image written into `wbmem`) onto a byte-wide output. The output uses a valid/ready handshake. It is the host-facing counterpart of the byte-serial `data_in` load path. It also produces a frame checksum so the host can verify each read-out.

---
 rtl/fleximac_pkg.sv | 14 +
 rtl/res_byte_mux.sv | 13 +
 rtl/res_streamer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fleximac_pkg.sv
// Shared constants and FSM state type for the fleximac accelerator.
package fleximac_pkg;
  localparam int RES_ROWS = 32;
  localparam int RES_COLS = 32;
  localparam int RES_W    = 8;
  localparam int RES_N    = RES_ROWS * RES_COLS;
  localparam int IDX_W    = 10;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;
endpackage

// File: rtl/res_byte_mux.sv
// Combinational N:1 element select from the flattened result bus.
// Kept as its own module so synthesis can build the wide mux tree in isolation.
module res_byte_mux #(
  parameter int N  = 1024,
  parameter int W  = 8,
  parameter int IW = 10
) (
  input  logic [W*N-1:0] res,
  input  logic [IW-1:0]  idx,
  output logic [W-1:0]   dat
);
  assign dat = res[idx*W +: W];
endmodule

// File: rtl/res_streamer.sv
// Serialises the result image onto a valid/ready byte stream with a frame checksum.
// First element one cycle after start; stalls in place while ready is low.
module res_streamer
  import fleximac_pkg::*;
#(
  parameter int ROWS = RES_ROWS,
  parameter int COLS = RES_COLS,
  parameter int W    = RES_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [W*ROWS*COLS-1:0] res,
  input  logic                 ready,
  output logic [W-1:0]         data_out,
  output logic                 valid,
  output logic                 last,
  output logic [5:0]           row,
  output logic [5:0]           col,
  output logic                 busy,
  output logic                 frame_done,
  output logic [W-1:0]         checksum
);
  localparam int N  = ROWS * COLS;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [5:0]    C_LAST = 6'(COLS - 1);

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [5:0]    row_q, row_d, col_q, col_d;
  logic [W-1:0]  data_q, data_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  cks_q, cks_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          done_q, done_d;

  logic [KW-1:0] sel;
  logic [W-1:0]  sel_dat;
  logic [KW-1:0] k_nxt;

  assign k_nxt = k_q + 1'b1;
  // Element 0 is fetched on start; afterwards always the one following k.
  assign sel   = (state_q == STREAM) ? k_nxt : '0;

  res_byte_mux #(
    .N  (N),
    .W  (W),
    .IW (KW)
  ) u_mux (
    .res (res),
    .idx (sel),
    .dat (sel_dat)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    row_d   = row_q;
    col_d   = col_q;
    data_d  = data_q;
    acc_d   = acc_q;
    cks_d   = cks_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          k_d     = '0;
          row_d   = '0;
          col_d   = '0;
          acc_d   = '0;
          data_d  = sel_dat;
          valid_d = 1'b1;
          last_d  = (K_LAST == '0);
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (valid_q && ready) begin
          acc_d = acc_q + data_q;
          if (k_q == K_LAST) begin
            // Raise frame_done/checksum now so they appear in the DONE cycle.
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            cks_d   = acc_q + data_q;
            state_d = DONE;
          end else begin
            k_d    = k_nxt;
            data_d = sel_dat;
            last_d = (k_nxt == K_LAST);
            if (col_q == C_LAST) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
      acc_q   <= '0;
      cks_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      row_q   <= row_d;
      col_q   <= col_d;
      data_q  <= data_d;
      acc_q   <= acc_d;
      cks_q   <= cks_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign data_out   = data_q;
  assign valid      = valid_q;
  assign last       = last_q;
  assign row        = row_q;
  assign col        = col_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = done_q;
  assign checksum   = cks_q;
endmodule
